// File: rtl/alu_seq_muldiv.sv
// Execute-stage ALU with a registered result behind a valid/ready handshake.
// Single-cycle logic/arith/shift/compare ops plus iterative signed/unsigned
// multiply (shift-add) and restoring divide on operand magnitudes.
module alu_seq_muldiv #(
  parameter int unsigned WORD_BITWIDTH = 32,
  parameter bit          ENABLE_MULDIV = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               operation,
  input  logic [WORD_BITWIDTH-1:0] addend1,
  input  logic [WORD_BITWIDTH-1:0] addend2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_BITWIDTH-1:0] result,
  output logic                     zero,
  output logic                     busy
);

  localparam int unsigned W  = WORD_BITWIDTH;
  localparam int unsigned SW = $clog2(WORD_BITWIDTH);

  typedef enum logic {IDLE, ITER} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic           neg_q, neg_d, is_mul_q, is_mul_d, sel_hi_q, sel_hi_d;
  logic [W-1:0]   result_q, result_d;
  logic           zero_q, zero_d, out_valid_q, out_valid_d;

  logic [SW-1:0]  shamt;
  logic [W-1:0]   simple_res;
  logic           accept, is_mop, is_div, is_signed, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag, min_val;
  logic [W:0]     mul_sum, div_tmp;
  logic           div_ge;
  logic [W-1:0]   hi_n, lo_n, div_word;
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   final_res;
  logic           load;
  logic [W-1:0]   load_val;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign busy      = (state_q == ITER);
  assign shamt     = addend2[SW-1:0];
  assign min_val   = {1'b1, {(W-1){1'b0}}};

  // Single-cycle operation results
  always_comb begin
    simple_res = '0;
    case (operation)
      4'b0000: simple_res = addend1 & addend2;
      4'b0001: simple_res = addend1 | addend2;
      4'b0010: simple_res = addend1 + addend2;
      4'b0011: simple_res = addend1 ^ addend2;
      4'b0100: simple_res = addend1 << shamt;
      4'b0101: simple_res = addend1 >> shamt;
      4'b0110: simple_res = addend1 - addend2;
      4'b0111: simple_res = {{(W-1){1'b0}}, (addend1 < addend2)};
      4'b1000: simple_res = $signed(addend1) >>> shamt;
      4'b1001: simple_res = {{(W-1){1'b0}}, ($signed(addend1) < $signed(addend2))};
      default: simple_res = '0;
    endcase
  end

  // M-op decode and operand magnitudes
  always_comb begin
    is_mop    = operation[3] && (operation[2] || operation[1]);
    is_div    = operation[3] && operation[2];
    is_signed = !is_div || !operation[0];
    a_neg     = is_signed && addend1[W-1];
    b_neg     = is_signed && addend2[W-1];
    a_mag     = a_neg ? (~addend1 + 1'b1) : addend1;
    b_mag     = b_neg ? (~addend2 + 1'b1) : addend2;
  end

  // One shift-add or restoring-divide step, plus sign fix-up of the next value
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
    div_tmp  = {hi_q, lo_q[W-1]};
    div_ge   = (div_tmp >= {1'b0, b_q});
    if (div_ge) div_tmp = div_tmp - {1'b0, b_q};
    if (is_mul_q) begin
      hi_n = mul_sum[W:1];
      lo_n = {mul_sum[0], lo_q[W-1:1]};
    end else begin
      hi_n = div_tmp[W-1:0];
      lo_n = {lo_q[W-2:0], div_ge};
    end
    prod     = {hi_n, lo_n};
    prod_s   = neg_q ? (~prod + 1'b1) : prod;
    div_word = sel_hi_q ? hi_n : lo_n;
    if (is_mul_q)
      final_res = sel_hi_q ? prod_s[2*W-1:W] : prod_s[W-1:0];
    else
      final_res = neg_q ? (~div_word + 1'b1) : div_word;
  end

  // Next-state, datapath and result-register control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    b_d         = b_q;
    neg_d       = neg_q;
    is_mul_d    = is_mul_q;
    sel_hi_d    = sel_hi_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q && !out_ready;
    load        = 1'b0;
    load_val    = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mop) begin
            load     = 1'b1;
            load_val = simple_res;
          end else if (!ENABLE_MULDIV) begin
            load     = 1'b1;
            load_val = '0;
          end else if (is_div && (addend2 == '0)) begin
            load     = 1'b1;
            load_val = operation[1] ? addend1 : '1;
          end else if (is_div && is_signed && (addend1 == min_val) && (addend2 == '1)) begin
            load     = 1'b1;
            load_val = operation[1] ? '0 : addend1;
          end else begin
            state_d  = ITER;
            cnt_d    = SW'(W - 1);
            hi_d     = '0;
            lo_d     = a_mag;
            b_d      = b_mag;
            is_mul_d = !is_div;
            sel_hi_d = is_div ? operation[1] : operation[0];
            // remainder takes the dividend's sign; product/quotient the xor
            neg_d    = (is_div && operation[1]) ? a_neg : (a_neg ^ b_neg);
          end
        end
      end
      ITER: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = IDLE;
          cnt_d    = '0;
          load     = 1'b1;
          load_val = final_res;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      result_d    = load_val;
      zero_d      = (load_val == '0);
      out_valid_d = 1'b1;
    end
  end

  // State and datapath registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      is_mul_q    <= 1'b0;
      sel_hi_q    <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      b_q         <= b_d;
      neg_q       <= neg_d;
      is_mul_q    <= is_mul_d;
      sel_hi_q    <= sel_hi_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv (W=32): vector table plus latency,
// back-pressure and reset-abort sequences.
module tb_alu_seq_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  operation = '0;
  logic [31:0] addend1 = '0;
  logic [31:0] addend2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_seq_muldiv #(.WORD_BITWIDTH(32), .ENABLE_MULDIV(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .addend1(addend1), .addend2(addend2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request with out_ready=1; lat counts edges from accept (=1) to out_valid
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat);
    operation = op; addend1 = a; addend2 = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    z   = zero;
  endtask

  vec_t        vecs[$];
  logic [31:0] r;
  logic        z;
  int          lat;
  int          bcnt;
  int          rdy_bad;

  initial begin
    vecs.push_back('{"add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1});
    vecs.push_back('{"sub",      4'b0110, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b0, 1});
    vecs.push_back('{"sra",      4'b1000, 32'h80000000, 32'h24,       32'hF8000000, 1'b0, 1});
    vecs.push_back('{"slt",      4'b1001, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1});
    vecs.push_back('{"sltu",     4'b0111, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1});
    vecs.push_back('{"and",      4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1});
    vecs.push_back('{"or",       4'b0001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1});
    vecs.push_back('{"xor",      4'b0011, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1});
    vecs.push_back('{"sll",      4'b0100, 32'h1,        32'h21,       32'h2,        1'b0, 1});
    vecs.push_back('{"srl",      4'b0101, 32'h80000000, 32'h1F,       32'h1,        1'b0, 1});
    vecs.push_back('{"mul_m1",   4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 33});
    vecs.push_back('{"mulh_m1",  4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b1, 33});
    vecs.push_back('{"mul_neg",  4'b1010, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33});
    vecs.push_back('{"mulh_pos", 4'b1011, 32'h40000000, 32'h4,        32'h1,        1'b0, 33});
    vecs.push_back('{"mulh_neg", 4'b1011, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 1'b0, 33});
    vecs.push_back('{"div_m7_2", 4'b1100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 1'b0, 33});
    vecs.push_back('{"rem_m7_2", 4'b1110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 1'b0, 33});
    vecs.push_back('{"div_7_m2", 4'b1100, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33});
    vecs.push_back('{"rem_7_m2", 4'b1110, 32'h7,        32'hFFFFFFFE, 32'h1,        1'b0, 33});
    vecs.push_back('{"divu",     4'b1101, 32'd100,      32'd7,        32'd14,       1'b0, 33});
    vecs.push_back('{"remu",     4'b1111, 32'd100,      32'd7,        32'd2,        1'b0, 33});
    vecs.push_back('{"divu_z",   4'b1101, 32'h7,        32'h0,        32'hFFFFFFFF, 1'b0, 1});
    vecs.push_back('{"remu_z",   4'b1111, 32'h7,        32'h0,        32'h7,        1'b0, 1});
    vecs.push_back('{"div_ovf",  4'b1100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1});
    vecs.push_back('{"rem_ovf",  4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b1, 1});

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_result",    result,         32'h0);
    chk("rst_zero",      32'(zero),      32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat);
      chk({vecs[i].name, "_res"},  r,        vecs[i].exp_res);
      chk({vecs[i].name, "_zero"}, 32'(z),   32'(vecs[i].exp_zero));
      chk({vecs[i].name, "_lat"},  32'(lat), 32'(vecs[i].exp_lat));
    end
    @(posedge clk); #1;
    chk("drain_out_valid", 32'(out_valid), 32'h0);

    // MUL: busy for 32 cycles with in_ready low throughout
    operation = 4'b1010; addend1 = 32'hFFFFFFFF; addend2 = 32'hFFFFFFFF;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bcnt = 0; rdy_bad = 0;
    while (busy && bcnt < 200) begin
      bcnt++;
      if (in_ready) rdy_bad++;
      @(posedge clk); #1;
    end
    chk("mul_busy_cycles", 32'(bcnt),      32'd32);
    chk("mul_ready_low",   32'(rdy_bad),   32'd0);
    chk("mul_done_valid",  32'(out_valid), 32'h1);
    chk("mul_done_res",    result,         32'h1);
    @(posedge clk); #1;

    // Back-pressure: result held for 5 cycles, then same-edge reload
    operation = 4'b0010; addend1 = 32'd10; addend2 = 32'd20;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_res",   result,         32'd30);
      chk("bp_ready", 32'(in_ready),  32'h0);
      @(posedge clk); #1;
    end
    operation = 4'b0010; addend1 = 32'd1; addend2 = 32'd1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("reload_valid", 32'(out_valid), 32'h1);
    chk("reload_res",   result,         32'd2);
    @(posedge clk); #1;
    chk("reload_drop", 32'(out_valid), 32'h0);

    // Reset mid-DIV aborts without emitting a result
    operation = 4'b1101; addend1 = 32'd100; addend2 = 32'd7;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("div_busy_mid", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'h0);
    chk("abort_busy",  32'(busy),      32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", 32'(in_ready),  32'h1);
    chk("abort_quiet", 32'(out_valid), 32'h0);
    run_op(4'b0010, 32'd2, 32'd3, r, z, lat);
    chk("post_rst_res", r,        32'd5);
    chk("post_rst_lat", 32'(lat), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
